// File: rtl/ttt_pkg.sv
// ---------------------------------------------------------------------------
// ttt_pkg : FSM encoding, default debounce length and grid bit indices shared
//           by the tic-tac-toe blocks.                              rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ttt_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  localparam int POS_W = 9;
  typedef logic [POS_W-1:0] pos_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Grid square bit positions: 8 is top-left, 0 is bottom-right.
  localparam int SQ_TL = 8;
  localparam int SQ_TM = 7;
  localparam int SQ_TR = 6;
  localparam int SQ_ML = 5;
  localparam int SQ_MM = 4;
  localparam int SQ_MR = 3;
  localparam int SQ_BL = 2;
  localparam int SQ_BM = 1;
  localparam int SQ_BR = 0;

endpackage

`default_nettype wire

// File: rtl/move_input_if.sv
// ---------------------------------------------------------------------------
// move_input_if : raw player inputs and the cleaned move signals handed to
//                 the game core.                                    rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface move_input_if;
  import ttt_pkg::*;

  pos_t sw_pos;
  logic btn_x_raw;
  logic btn_o_raw;
  pos_t sel_pos;
  logic buttonX;
  logic buttonO;
  logic busy;

  modport master (
    output sw_pos, btn_x_raw, btn_o_raw,
    input  sel_pos, buttonX, buttonO, busy
  );

  modport slave (
    input  sw_pos, btn_x_raw, btn_o_raw,
    output sel_pos, buttonX, buttonO, busy
  );

endinterface

`default_nettype wire

// File: rtl/debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit : two-flop synchronizer followed by a stability counter that
//                toggles the debounced level after a full stable period. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = ttt_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b00;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // Toggle one cycle after the counter reaches LIMIT, so it never wraps.
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (cnt >= LIMIT) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/move_input.sv
// ---------------------------------------------------------------------------
// move_input : synchronizes switches, debounces both player buttons and turns
//              each accepted press into a one-cycle move strobe.    rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module move_input
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic         clk,
  input  logic         reset,
  move_input_if.slave  io
);

  pos_t       pos_s1;
  pos_t       pos_s2;
  pos_t       sel_pos_q;
  logic       db_x;
  logic       db_o;
  logic [1:0] state;
  logic       fire_x;
  logic       fire_o;

  debounce_bit #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_x (
    .clk   (clk),
    .reset (reset),
    .raw   (io.btn_x_raw),
    .db    (db_x)
  );

  debounce_bit #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_o (
    .clk   (clk),
    .reset (reset),
    .raw   (io.btn_o_raw),
    .db    (db_o)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_s1    <= '0;
      pos_s2    <= '0;
      sel_pos_q <= '0;
      fire_x    <= 1'b0;
      fire_o    <= 1'b0;
      state     <= ST_IDLE;
    end else begin
      pos_s1 <= io.sw_pos;
      pos_s2 <= pos_s1;
      case (state)
        // HOLD only exits with both levels low, so any high level seen in
        // IDLE is necessarily a fresh rising edge.
        ST_IDLE: begin
          if (db_x || db_o) begin
            sel_pos_q <= pos_s2;
            fire_x    <= db_x;
            fire_o    <= db_o;
            state     <= ST_FIRE;
          end
        end
        ST_FIRE: state <= ST_HOLD;
        ST_HOLD: begin
          if (!db_x && !db_o) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign io.sel_pos = sel_pos_q;
  assign io.buttonX = (state == ST_FIRE) && fire_x;
  assign io.buttonO = (state == ST_FIRE) && fire_o;
  assign io.busy    = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_move_input.sv
// ---------------------------------------------------------------------------
// tb_move_input : directed presses with a strobe scoreboard for move_input.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_move_input;

  localparam int DB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  move_input_if mif ();

  move_input #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] at;
    logic        x;
    logic        o;
    logic [8:0]  pos;
  } ev_t;

  ev_t expq[$];
  int  passed = 0;
  int  total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  // Strobe must show up in the cycle following edge (press edge + 3 + DB).
  task automatic expect_strobe(input logic x, input logic o, input logic [8:0] p);
    ev_t e;
    e.at  = 32'(cyc + 4 + DB);
    e.x   = x;
    e.o   = o;
    e.pos = p;
    expq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (!reset && (mif.buttonX || mif.buttonO)) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL unexpected_strobe: got x=%0b o=%0b at cycle %0d, expected none",
                 mif.buttonX, mif.buttonO, cyc);
      end else begin
        e = expq.pop_front();
        check("strobe_cycle", 32'(cyc), e.at);
        check("strobe_x", 32'(mif.buttonX), 32'(e.x));
        check("strobe_o", 32'(mif.buttonO), 32'(e.o));
        check("strobe_sel_pos", 32'(mif.sel_pos), 32'(e.pos));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: got no end of stimulus, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    mif.sw_pos    = 9'h000;
    mif.btn_x_raw = 1'b0;
    mif.btn_o_raw = 1'b0;
    tick(2);
    check("reset_sel_pos", 32'(mif.sel_pos), 32'h0);
    check("reset_buttonX", 32'(mif.buttonX), 32'h0);
    check("reset_buttonO", 32'(mif.buttonO), 32'h0);
    check("reset_busy", 32'(mif.busy), 32'h0);
    reset = 1'b0;

    // Clean X press
    mif.sw_pos = 9'h010;
    tick(3);
    mif.btn_x_raw = 1'b1;
    expect_strobe(1'b1, 1'b0, 9'h010);
    tick(12);
    check("clean_busy_held", 32'(mif.busy), 32'h1);
    check("clean_sel_pos", 32'(mif.sel_pos), 32'h010);
    mif.btn_x_raw = 1'b0;
    tick(2);
    check("busy_during_release", 32'(mif.busy), 32'h1);
    tick(14);
    check("busy_after_release", 32'(mif.busy), 32'h0);

    // Bouncy X press: 3-cycle pulses must not strobe
    repeat (2) begin
      mif.btn_x_raw = 1'b1;
      tick(3);
      mif.btn_x_raw = 1'b0;
      tick(2);
    end
    check("bounce_no_busy", 32'(mif.busy), 32'h0);
    mif.btn_x_raw = 1'b1;
    expect_strobe(1'b1, 1'b0, 9'h010);
    tick(12);
    mif.btn_x_raw = 1'b0;
    tick(16);

    // X and O together
    mif.sw_pos = 9'h040;
    tick(3);
    mif.btn_x_raw = 1'b1;
    mif.btn_o_raw = 1'b1;
    expect_strobe(1'b1, 1'b1, 9'h040);
    tick(12);
    mif.btn_x_raw = 1'b0;
    mif.btn_o_raw = 1'b0;
    tick(16);

    // O pressed while X held; switches move during HOLD
    mif.sw_pos = 9'h001;
    tick(3);
    mif.btn_x_raw = 1'b1;
    expect_strobe(1'b1, 1'b0, 9'h001);
    tick(12);
    mif.btn_o_raw = 1'b1;
    mif.sw_pos    = 9'h100;
    tick(12);
    check("hold_sel_pos_frozen", 32'(mif.sel_pos), 32'h001);
    check("hold_busy", 32'(mif.busy), 32'h1);
    mif.btn_x_raw = 1'b0;
    mif.btn_o_raw = 1'b0;
    tick(16);
    mif.btn_o_raw = 1'b1;
    expect_strobe(1'b0, 1'b1, 9'h100);
    tick(12);
    check("next_press_sel_pos", 32'(mif.sel_pos), 32'h100);
    mif.btn_o_raw = 1'b0;
    tick(16);

    // Multi-hot position passes through
    mif.sw_pos = 9'h003;
    tick(3);
    mif.btn_x_raw = 1'b1;
    expect_strobe(1'b1, 1'b0, 9'h003);
    tick(12);
    check("multihot_sel_pos", 32'(mif.sel_pos), 32'h003);
    mif.btn_x_raw = 1'b0;
    tick(16);

    // Reset during FIRE drops the strobe; X held across release strobes once
    mif.btn_x_raw = 1'b1;
    repeat (4 + DB) @(posedge clk);
    #1;
    check("fire_before_reset", 32'(mif.buttonX), 32'h1);
    reset = 1'b1;
    #1;
    check("reset_mid_buttonX", 32'(mif.buttonX), 32'h0);
    check("reset_mid_busy", 32'(mif.busy), 32'h0);
    check("reset_mid_sel_pos", 32'(mif.sel_pos), 32'h0);
    tick(2);
    reset = 1'b0;
    expect_strobe(1'b1, 1'b0, 9'h003);
    tick(12);
    mif.btn_x_raw = 1'b0;
    tick(16);

    check("all_strobes_seen", 32'(expq.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/move_input.md
# move_input

Player-input front end for the tic-tac-toe game core. It synchronizes nine raw position switches and the two raw player buttons, then debounces the buttons. It converts each accepted press into a single-cycle move strobe with a registered position snapshot, producing the `sel_pos` / `buttonX` / `buttonO` inputs the game core consumes. Legality checks (occupied square, multi-hot position, wrong turn) remain in the game core; this block delivers exactly what the player set, cleanly, once per press.

## Interface
- `DEBOUNCE_CYCLES`, 50000: consecutive stable synchronized cycles required before a button level change is accepted (≥1).
- `CNT_W`, 16: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  reset is asynchronous and active-high.
- `sw_pos`  in  9  raw position switches, asynchronous; bit i = grid square i (8 top-left … 0 bottom-right).
- `btn_x_raw`  in  1  raw X-player button, asynchronous, bouncy.
- `btn_o_raw`  in  1  raw O-player button, asynchronous, bouncy.
- `sel_pos`  out  9  synchronized `sw_pos` captured on the accepting cycle; held until the next accept.
- `buttonX`  out  1  one-cycle move strobe for X.
- `buttonO`  out  1  one-cycle move strobe for O.
- `busy`  out  1  high from an accepted press until both debounced buttons are released.

## Operation
- Two-flop synchronizer on all 11 raw inputs; nothing downstream sees unsynchronized data.
- Per button, `debounce_bit`:
  - keeps debounced level `db`;
  - counter clears whenever the synchronized input equals `db`, otherwise increments;
  - on reaching `DEBOUNCE_CYCLES`, `db` toggles and the counter clears.
- FSM states: IDLE, FIRE, HOLD.
  - IDLE: on rising `db_x` and/or `db_o`, latch synchronized `sw_pos` into `sel_pos` and go to FIRE.
  - FIRE (exactly 1 cycle): assert `buttonX` if `db_x` rose, `buttonO` if `db_o` rose. Both strobes fire together if both rose in the same cycle; the game core flags that as an error. Go to HOLD.
  - HOLD: wait until `db_x`=0 and `db_o`=0, then go to IDLE.
- A second button debouncing high while in FIRE/HOLD produces no strobe. One strobe set per press episode.
- `sel_pos` is passed through unmodified, including zero-hot or multi-hot values. It does not change outside the accept cycle, so switch motion during HOLD is invisible to the game core.
- `busy` = (state != IDLE).

## Timing
- Reset values: `sel_pos`=0, `buttonX`=0, `buttonO`=0, `busy`=0; synchronizers 0, `db_*`=0, counters 0, FSM IDLE.
- Latency: raw button stable high from clock edge n → `db` high after edge n+2+`DEBOUNCE_CYCLES` → `buttonX`/`buttonO` high for the single cycle after edge n+3+`DEBOUNCE_CYCLES`.
- `sel_pos` becomes valid on the same edge the strobe rises and stays stable at least until the next strobe.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles never change `db` and never strobe.
- Release path uses the same debounce. The earliest next strobe is 1 cycle after `db` of both buttons reads 0 plus a new full debounce period.
- Reset mid-operation: all state clears immediately (asynchronous), and any in-flight strobe is dropped. A button held through reset deassertion debounces from `db`=0 and yields exactly one strobe after the normal latency.
- Counter saturates semantically at `DEBOUNCE_CYCLES`; it never wraps.

## Structure
- Shared package `ttt_pkg`:
  - FSM state encoding (IDLE/FIRE/HOLD);
  - default `DEBOUNCE_CYCLES`;
  - the grid bit-index constants shared with the game core and win checker.
- One sub-module `debounce_bit` (synchronizer + counter + `db` register, parameterized by `DEBOUNCE_CYCLES`/`CNT_W`), instantiated once per button.
- Position switches use only the synchronizer. The FSM and `sel_pos` register live in `move_input`.

## Test plan (`DEBOUNCE_CYCLES`=4)
- Clean X press, `sw_pos`=9'h010 held → exactly one `buttonX` pulse, 7 cycles after the first sampling edge; `sel_pos`=9'h010; `buttonO` stays 0; `busy` high until release is debounced.
- X press with 3-cycle bounce pulses before a stable high → no strobe during the bounce; single strobe 7 cycles after the final stable edge.
- X and O rise together → `buttonX`=`buttonO`=1 in the same cycle, once.
- O pressed while X held in HOLD → no `buttonO`.
- `sw_pos` changed 9'h001→9'h100 during HOLD → `sel_pos` remains 9'h001; next press captures 9'h100. Multi-hot 9'h003 press → `sel_pos`=9'h003 passed unmodified.
- Reset asserted mid-FIRE → strobe and outputs drop to 0 on the same edge. X held across reset release → one `buttonX` 7 cycles after release.
